fir_tap_ctrl: RTL and testbench

FIR_TAP_CTRL -- requirements
Module: fir_tap_ctrl

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_coef_bank.sv | 49 ++++
 rtl/fir_tap_ctrl.sv | 150 +++++++++++++++
 tb/tb_fir_tap_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap controller slice.
//   fir_state_e   : controller FSM state encodings (visible on ov_state)
//   FirStateWidth : width of the encoded state
//   weight_lsb()  : LSB of tap k's weight inside the flat weight bus
package fir_pkg;

    localparam int unsigned FirStateWidth = 2;

    typedef enum logic [FirStateWidth-1:0] {
        StIdle   = 2'd0,
        StLoad   = 2'd1,
        StCommit = 2'd2,
        StRun    = 2'd3
    } fir_state_e;

    // Tap 0 is the output end of the transposed chain and sits at bit 0.
    function automatic int unsigned weight_lsb(input int unsigned tap, input int unsigned width);
        return tap * width;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register bank: a shadow bank written one word at a time and an
// active bank that takes a full copy of the shadow bank on a commit strobe.
// Values are stored verbatim.
//   i_clk, i_rst : clock, synchronous active-high reset (clears both banks)
//   wr_en_i      : write shadow[wr_addr_i] <= wr_data_i
//   commit_i     : copy shadow bank to active bank
//   weights_o    : active bank, tap k at [k*DATA_WIDTH +: DATA_WIDTH]
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned NUM_TAPS   = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(NUM_TAPS)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           wr_en_i,
    input  logic [ADDR_WIDTH-1:0]          wr_addr_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    input  logic                           commit_i,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] weights_o
);

    logic [DATA_WIDTH-1:0] shadow_q [NUM_TAPS];
    logic [DATA_WIDTH-1:0] active_q [NUM_TAPS];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < NUM_TAPS; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_TAPS; k++) begin
                if (wr_en_i && (wr_addr_i == ADDR_WIDTH'(k))) begin
                    shadow_q[k] <= wr_data_i;
                end
                if (commit_i) begin
                    active_q[k] <= shadow_q[k];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_flat
        assign weights_o[weight_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = active_q[k];
    end

endmodule

// File: rtl/fir_tap_ctrl.sv
// Controller for a transposed FIR tap chain: loads coefficients into a shadow
// bank, commits them atomically while clearing the chain, and streams samples
// through the chain with a one-cycle accept-to-output latency.
//   i_clk, i_rst                         : clock, synchronous active-high reset
//   i_load_req                           : pulse, start a coefficient reload
//   i_coef_valid, iv_coef, o_coef_ready  : coefficient stream (LOAD only)
//   i_s_valid, iv_s_data, o_s_ready      : input sample stream
//   o_tap_en, ov_tap_din, o_chain_clr    : tap chain enable / broadcast sample / clear
//   ov_weights                           : active weights, tap 0 = output end at bit 0
//   iv_chain_sum                         : tap 0 sum from the chain
//   o_m_valid, ov_m_data, i_m_ready      : output stream
//   ov_state                             : current FSM state
module fir_tap_ctrl
    import fir_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned NUM_TAPS   = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_load_req,
    input  logic                           i_coef_valid,
    input  logic [DATA_WIDTH-1:0]          iv_coef,
    output logic                           o_coef_ready,
    input  logic                           i_s_valid,
    input  logic [DATA_WIDTH-1:0]          iv_s_data,
    output logic                           o_s_ready,
    output logic                           o_tap_en,
    output logic [DATA_WIDTH-1:0]          ov_tap_din,
    output logic                           o_chain_clr,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights,
    input  logic [DATA_WIDTH-1:0]          iv_chain_sum,
    output logic                           o_m_valid,
    output logic [DATA_WIDTH-1:0]          ov_m_data,
    input  logic                           i_m_ready,
    output logic [FirStateWidth-1:0]       ov_state
);

    localparam int unsigned CntWidth = $clog2(NUM_TAPS);
    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NUM_TAPS - 1);

    fir_state_e          state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                from_run_q, from_run_d;
    logic                m_valid_q, m_valid_d;

    logic coef_ready;
    logic coef_hs;
    logic s_ready;
    logic commit;
    logic stream_ready;

    // Output register is free, or is being drained this cycle.
    assign stream_ready = !m_valid_q || i_m_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        from_run_d = from_run_q;
        coef_ready = 1'b0;
        s_ready    = 1'b0;
        commit     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_load_req) begin
                    state_d    = StLoad;
                    from_run_d = 1'b0;
                end
            end
            StLoad: begin
                coef_ready = 1'b1;
                // A reload started from RUN keeps the old weights streaming.
                s_ready    = from_run_q && stream_ready;
                if (i_coef_valid) begin
                    if (cnt_q == LastCnt) begin
                        cnt_d   = '0;
                        state_d = StCommit;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StCommit: begin
                commit  = 1'b1;
                state_d = StRun;
            end
            StRun: begin
                s_ready = stream_ready;
                if (i_load_req) begin
                    state_d    = StLoad;
                    from_run_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset forces every handshake low and holds the chain clear.
    assign o_coef_ready = coef_ready && !i_rst;
    assign o_s_ready    = s_ready && !i_rst;
    assign o_tap_en     = i_s_valid && o_s_ready;
    assign o_chain_clr  = i_rst || (state_q == StCommit);
    assign coef_hs      = i_coef_valid && o_coef_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        if (commit) begin
            m_valid_d = 1'b0;
        end else if (o_tap_en) begin
            m_valid_d = 1'b1;
        end else if (m_valid_q && i_m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            from_run_q <= 1'b0;
            m_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            from_run_q <= from_run_d;
            m_valid_q  <= m_valid_d;
        end
    end

    fir_coef_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_TAPS   (NUM_TAPS),
        .ADDR_WIDTH (CntWidth)
    ) u_coef_bank (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .wr_en_i   (coef_hs),
        .wr_addr_i (cnt_q),
        .wr_data_i (iv_coef),
        .commit_i  (commit && !i_rst),
        .weights_o (ov_weights)
    );

    assign ov_tap_din = iv_s_data;
    assign ov_m_data  = iv_chain_sum;
    assign o_m_valid  = m_valid_q;
    assign ov_state   = state_q;

endmodule

// File: tb/tb_fir_tap_ctrl.sv
// Directed bench for fir_tap_ctrl driving a behavioural transposed tap chain.
module tb_fir_tap_ctrl;

    localparam int unsigned DW = 24;
    localparam int unsigned NT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_req;
    logic             coef_valid;
    logic [DW-1:0]    coef;
    logic             coef_ready;
    logic             s_valid;
    logic [DW-1:0]    s_data;
    logic             s_ready;
    logic             tap_en;
    logic [DW-1:0]    tap_din;
    logic             chain_clr;
    logic [NT*DW-1:0] weights;
    logic [DW-1:0]    chain_sum;
    logic             m_valid;
    logic [DW-1:0]    m_data;
    logic             m_ready;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    // Impulse 0.5 through weights (k+1)/8; the last weight 0x800000 is -1.0.
    logic [DW-1:0] imp_exp [NT] = '{24'h080000, 24'h100000, 24'h180000, 24'h200000,
                                   24'h280000, 24'h300000, 24'h380000, 24'hC00000};

    always #5 clk = ~clk;

    fir_tap_ctrl #(.DATA_WIDTH(DW), .NUM_TAPS(NT)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_load_req   (load_req),
        .i_coef_valid (coef_valid),
        .iv_coef      (coef),
        .o_coef_ready (coef_ready),
        .i_s_valid    (s_valid),
        .iv_s_data    (s_data),
        .o_s_ready    (s_ready),
        .o_tap_en     (tap_en),
        .ov_tap_din   (tap_din),
        .o_chain_clr  (chain_clr),
        .ov_weights   (weights),
        .iv_chain_sum (chain_sum),
        .o_m_valid    (m_valid),
        .ov_m_data    (m_data),
        .i_m_ready    (m_ready),
        .ov_state     (state)
    );

    // Transposed tap chain: tap NT-1 takes iv_sum = 0, tap 0 feeds the output.
    logic [DW-1:0] tap_q [NT];

    function automatic logic [DW-1:0] qmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [2*DW-1:0] p;
        p = $signed(a) * $signed(b);
        return p[2*DW-2:DW-1];
    endfunction

    always @(posedge clk) begin
        if (chain_clr) begin
            for (int k = 0; k < NT; k++) tap_q[k] <= '0;
        end else if (tap_en) begin
            for (int k = 0; k < NT - 1; k++) begin
                tap_q[k] <= qmul(tap_din, weights[k*DW +: DW]) + tap_q[k+1];
            end
            tap_q[NT-1] <= qmul(tap_din, weights[(NT-1)*DW +: DW]);
        end
    end
    assign chain_sum = tap_q[0];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_req = 1'b0; coef_valid = 1'b1; coef = 24'h123456;
        s_valid = 1'b1; s_data = 24'h3FFFFF; m_ready = 1'b1;
        tick();
        checks++; if (chain_clr !== 1'b1) begin errors++; $display("FAIL rst_chain_clr: got %b want 1", chain_clr); end
        checks++; if (coef_ready !== 1'b0) begin errors++; $display("FAIL rst_coef_ready: got %b want 0", coef_ready); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        checks++; if (tap_en !== 1'b0) begin errors++; $display("FAIL rst_tap_en: got %b want 0", tap_en); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        checks++; if (weights !== '0) begin errors++; $display("FAIL rst_weights: got %h want 0", weights); end
        tick();
        rst = 1'b0;
        #1;
        // IDLE: no coefficient or sample may be taken.
        checks++; if (coef_ready !== 1'b0) begin errors++; $display("FAIL idle_coef_ready: got %b want 0", coef_ready); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL idle_s_ready: got %b want 0", s_ready); end
        tick();
        checks++; if (weights !== '0) begin errors++; $display("FAIL idle_weights: got %h want 0", weights); end
        coef_valid = 1'b0; s_valid = 1'b0; s_data = '0;
    endtask

    task automatic test_load_coefs();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL load_enter: got %0d want 1", state); end
        checks++; if (coef_ready !== 1'b1) begin errors++; $display("FAIL load_coef_ready: got %b want 1", coef_ready); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL load_s_ready: got %b want 0", s_ready); end
        for (int i = 0; i < NT; i++) begin
            coef_valid = 1'b1;
            coef = 24'((i + 1) * 24'h100000);
            tick();
            if (i < NT - 1) begin
                checks++; if (state !== 2'd1) begin errors++; $display("FAIL load_state_%0d: got %0d want 1", i, state); end
                checks++; if (weights !== '0) begin errors++; $display("FAIL load_weights_held_%0d: got %h want 0", i, weights); end
            end
        end
        coef_valid = 1'b0;
        s_valid = 1'b1; s_data = 24'h7FFFFF;
        #1;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL commit_state: got %0d want 2", state); end
        checks++; if (chain_clr !== 1'b1) begin errors++; $display("FAIL commit_clr: got %b want 1", chain_clr); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL commit_s_ready: got %b want 0", s_ready); end
        checks++; if (tap_en !== 1'b0) begin errors++; $display("FAIL commit_tap_en: got %b want 0", tap_en); end
        tick();
        s_valid = 1'b0; s_data = '0;
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL run_state: got %0d want 3", state); end
        checks++; if (chain_clr !== 1'b0) begin errors++; $display("FAIL run_clr: got %b want 0", chain_clr); end
        for (int k = 0; k < NT; k++) begin
            checks++;
            if (weights[k*DW +: DW] !== 24'((k + 1) * 24'h100000)) begin
                errors++; $display("FAIL weight_slot_%0d: got %h want %h", k, weights[k*DW +: DW], 24'((k + 1) * 24'h100000));
            end
        end
    endtask

    task automatic test_impulse();
        logic [DW-1:0] want;
        m_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'b1;
            s_data = (i == 0) ? 24'h400000 : 24'h000000;
            #1;
            checks++; if (tap_en !== 1'b1) begin errors++; $display("FAIL imp_tap_en_%0d: got %b want 1", i, tap_en); end
            tick();
            want = (i < NT) ? imp_exp[i] : '0;
            checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL imp_valid_%0d: got %b want 1", i, m_valid); end
            checks++; if (m_data !== want) begin errors++; $display("FAIL imp_data_%0d: got %h want %h", i, m_data, want); end
        end
        s_valid = 1'b0;
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL imp_drain: got %b want 0", m_valid); end
    endtask

    task automatic test_backpressure();
        int in_idx = 0;
        int out_idx = 0;
        bit in_stall = 1'b0;
        logic [DW-1:0] hold = '0;
        logic [DW-1:0] want;
        for (int cyc = 0; cyc < 40 && out_idx < 12; cyc++) begin
            s_valid = (in_idx < 12);
            s_data  = (in_idx == 0) ? 24'h400000 : 24'h000000;
            m_ready = !(cyc >= 4 && cyc < 9);
            #1;
            if (!m_ready && m_valid) begin
                checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready_%0d: got %b want 0", cyc, s_ready); end
                checks++; if (tap_en !== 1'b0) begin errors++; $display("FAIL bp_tap_en_%0d: got %b want 0", cyc, tap_en); end
                if (in_stall) begin
                    checks++; if (m_data !== hold) begin errors++; $display("FAIL bp_hold_%0d: got %h want %h", cyc, m_data, hold); end
                end
                hold = m_data;
                in_stall = 1'b1;
            end else begin
                in_stall = 1'b0;
            end
            if (m_valid && m_ready) begin
                want = (out_idx < NT) ? imp_exp[out_idx] : '0;
                checks++; if (m_data !== want) begin errors++; $display("FAIL bp_data_%0d: got %h want %h", out_idx, m_data, want); end
                out_idx++;
            end
            if (tap_en) in_idx++;
            tick();
        end
        checks++; if (out_idx != 12) begin errors++; $display("FAIL bp_out_count: got %0d want 12", out_idx); end
        checks++; if (in_idx != 12) begin errors++; $display("FAIL bp_in_count: got %0d want 12", in_idx); end
        s_valid = 1'b0; m_ready = 1'b1;
        tick();
    endtask

    task automatic test_reload();
        logic [DW-1:0] want;
        logic [1:0] want_state;
        m_ready = 1'b1;
        for (int c = 0; c < 11; c++) begin
            s_valid = 1'b1;
            s_data = (c == 5) ? 24'h400000 : 24'h000000;
            load_req = (c == 2);
            coef_valid = (c >= 3);
            coef = 24'h080000;
            #1;
            checks++; if (tap_en !== 1'b1) begin errors++; $display("FAIL rl_tap_en_%0d: got %b want 1", c, tap_en); end
            tick();
            want = (c < 5) ? 24'h000000 : imp_exp[c-5];
            want_state = (c < 2) ? 2'd3 : ((c < 10) ? 2'd1 : 2'd2);
            checks++; if (m_data !== want) begin errors++; $display("FAIL rl_data_%0d: got %h want %h", c, m_data, want); end
            checks++; if (state !== want_state) begin errors++; $display("FAIL rl_state_%0d: got %0d want %0d", c, state, want_state); end
            if (c == 9) begin
                checks++; if (weights[7*DW +: DW] !== 24'h800000) begin errors++; $display("FAIL rl_old_weight: got %h want 800000", weights[7*DW +: DW]); end
            end
        end
        load_req = 1'b0; coef_valid = 1'b0;
        s_valid = 1'b1; s_data = 24'h400000;
        #1;
        checks++; if (chain_clr !== 1'b1) begin errors++; $display("FAIL rl_commit_clr: got %b want 1", chain_clr); end
        checks++; if (tap_en !== 1'b0) begin errors++; $display("FAIL rl_commit_tap_en: got %b want 0", tap_en); end
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rl_commit_valid: got %b want 0", m_valid); end
        for (int k = 0; k < NT; k++) begin
            checks++; if (weights[k*DW +: DW] !== 24'h080000) begin errors++; $display("FAIL rl_new_weight_%0d: got %h want 080000", k, weights[k*DW +: DW]); end
        end
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data = (i == 0) ? 24'h400000 : 24'h000000;
            tick();
            want = (i < NT) ? 24'h040000 : 24'h000000;
            checks++; if (m_data !== want) begin errors++; $display("FAIL rl_post_%0d: got %h want %h", i, m_data, want); end
        end
        s_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_midload();
        logic [NT*DW-1:0] held;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            coef_valid = 1'b1; coef = 24'h111111;
            tick();
        end
        coef_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL ml_rst_state: got %0d want 0", state); end
        checks++; if (weights !== '0) begin errors++; $display("FAIL ml_rst_weights: got %h want 0", weights); end
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        for (int i = 0; i < NT; i++) begin
            if (i == 3) begin
                coef_valid = 1'b0; load_req = 1'b1;
                tick();
                load_req = 1'b0;
                checks++; if (state !== 2'd1) begin errors++; $display("FAIL ml_ignore_req: got %0d want 1", state); end
            end
            coef_valid = 1'b1; coef = 24'((i + 1) * 24'h010101);
            tick();
        end
        coef_valid = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL ml_commit: got %0d want 2", state); end
        tick();
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL ml_run: got %0d want 3", state); end
        for (int k = 0; k < NT; k++) begin
            checks++;
            if (weights[k*DW +: DW] !== 24'((k + 1) * 24'h010101)) begin
                errors++; $display("FAIL ml_weight_%0d: got %h want %h", k, weights[k*DW +: DW], 24'((k + 1) * 24'h010101));
            end
        end
        // A coefficient offered in RUN must not be taken.
        held = weights;
        coef_valid = 1'b1; coef = 24'h7FFFFF;
        #1;
        checks++; if (coef_ready !== 1'b0) begin errors++; $display("FAIL run_coef_ready: got %b want 0", coef_ready); end
        tick();
        tick();
        coef_valid = 1'b0;
        checks++; if (weights !== held) begin errors++; $display("FAIL run_coef_ignored: got %h want %h", weights, held); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_coefs();
        test_impulse();
        test_backpressure();
        test_reload();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
